// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing the single SD sector channel between NREQ requesters.
// One sector transfer at a time; the SD byte buffer is routed to/from the current owner.
module sd_sector_arbiter #(
    parameter int          NREQ    = 3,
    parameter int          LBA_W   = 32,
    parameter logic [23:0] TIMEOUT = 24'd16777215
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_rd,
    input  logic [NREQ-1:0]         req_wr,
    input  logic [NREQ*LBA_W-1:0]   req_lba,
    input  logic [NREQ*8-1:0]       req_din,
    output logic [NREQ-1:0]         req_grant,
    output logic [NREQ-1:0]         req_done,
    output logic                    req_err,
    output logic [NREQ-1:0]         buf_wr,
    output logic [8:0]              buf_addr,
    output logic [7:0]              buf_dout,
    output logic                    sd_rd,
    output logic                    sd_wr,
    output logic [LBA_W-1:0]        sd_lba,
    input  logic                    sd_ack,
    input  logic [8:0]              sd_buff_addr,
    input  logic [7:0]              sd_buff_dout,
    input  logic                    sd_buff_wr,
    output logic [7:0]              sd_buff_din
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic             rd_q, rd_d;
    logic             err_q, err_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic [23:0]      cnt_q, cnt_d;

    logic [NREQ-1:0]  pend;
    logic [NREQ-1:0]  own_oh;
    logic             found;
    logic [IW-1:0]    sel;

    // First pending requester at or after the round-robin pointer.
    always_comb begin
        pend  = req_rd | req_wr;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && pend[IW'(j)]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) own_oh[i] = (owner_q == IW'(i));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            lba_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        rd_d    = rd_q;
        err_d   = err_q;
        lba_d   = lba_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d = sel;
                    rd_d    = req_rd[sel];  // read wins over write
                    lba_d   = req_lba[int'(sel)*LBA_W +: LBA_W];
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sd_ack) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else if (cnt_q == TIMEOUT - 24'd1) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_XFER: begin
                if (!sd_ack) state_d = S_DONE;
            end
            S_DONE: begin
                rr_d    = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request lines drop combinationally on sd_ack so the SD side sees a single-edge handshake.
    always_comb begin
        req_grant   = (state_q != S_IDLE) ? own_oh : '0;
        req_done    = (state_q == S_DONE) ? own_oh : '0;
        req_err     = (state_q == S_DONE) && err_q;
        sd_rd       = (state_q == S_ISSUE) &&  rd_q && !sd_ack;
        sd_wr       = (state_q == S_ISSUE) && !rd_q && !sd_ack;
        sd_lba      = lba_q;
        buf_wr      = (state_q == S_XFER && sd_buff_wr) ? own_oh : '0;
        buf_addr    = sd_buff_addr;
        buf_dout    = sd_buff_dout;
        sd_buff_din = (state_q == S_XFER) ? req_din[int'(owner_q)*8 +: 8] : 8'h00;
    end

endmodule
